// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// default operand widths.
package div_pkg;

  localparam int N_DEFAULT  = 8;
  localparam int DW_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int DW = 7
) (
  input  logic [DW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_div,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);

  logic [DW:0]   w_shift;
  logic [DW+1:0] w_diff;
  logic          w_unused;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_div};
  assign o_qbit  = ~w_diff[DW+1];

  // The kept partial remainder is always below the divisor, so it fits in DW bits.
  assign o_rem    = o_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
  assign w_unused = w_diff[DW];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider: N iterations (one per cycle)
// followed by a sign-correction cycle, with abort and divide-by-zero handling.
module seq_divider
  import div_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int SIGNED_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          signed_op,
  input  logic [N-1:0]  dividendin,
  input  logic [DW-1:0] divisorin,
  output logic          busy,
  output logic          dout_valid,
  output logic [N-1:0]  quotient,
  output logic [DW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = $clog2(N);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_dq;
  logic [DW-1:0] r_prem;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_dvd_lo;
  logic          r_qneg;
  logic          r_rneg;
  logic          r_zero;
  logic [N-1:0]  r_quotient;
  logic [DW-1:0] r_remainder;
  logic          r_dbz;
  logic          r_dout_valid;

  logic          w_load;
  logic          w_step;
  logic          w_fix;
  logic          w_sgn;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [N-1:0]  w_a_mag;
  logic [DW-1:0] w_b_mag;
  logic [DW-1:0] w_prem_next;
  logic          w_qbit;

  generate
    if (SIGNED_EN != 0) begin : g_signed
      assign w_sgn = signed_op;
    end else begin : g_unsigned
      logic w_unused_signed;
      assign w_sgn           = 1'b0;
      assign w_unused_signed = signed_op;
    end
  endgenerate

  assign w_a_neg = w_sgn & dividendin[N-1];
  assign w_b_neg = w_sgn & divisorin[DW-1];
  assign w_a_mag = w_a_neg ? -dividendin : dividendin;
  assign w_b_mag = w_b_neg ? -divisorin : divisorin;

  // r_dq starts as the dividend magnitude; each step shifts out its MSB and
  // shifts the new quotient bit into the LSB, leaving the quotient after N steps.
  div_step #(
    .DW(DW)
  ) u_step (
    .i_rem (r_prem),
    .i_bit (r_dq[N-1]),
    .i_div (r_div),
    .o_rem (w_prem_next),
    .o_qbit(w_qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == '0) w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = IDLE;
        if (!abort) w_fix = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_dq         <= '0;
      r_prem       <= '0;
      r_div        <= '0;
      r_dvd_lo     <= '0;
      r_qneg       <= 1'b0;
      r_rneg       <= 1'b0;
      r_zero       <= 1'b0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_dbz        <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_load) begin
        r_cnt    <= CW'(N - 1);
        r_dq     <= w_a_mag;
        r_prem   <= '0;
        r_div    <= w_b_mag;
        r_dvd_lo <= dividendin[DW-1:0];
        r_qneg   <= w_a_neg ^ w_b_neg;
        r_rneg   <= w_a_neg;
        r_zero   <= (divisorin == '0);
      end
      if (w_step) begin
        r_cnt  <= r_cnt - CW'(1);
        r_dq   <= {r_dq[N-2:0], w_qbit};
        r_prem <= w_prem_next;
      end
      if (w_fix) begin
        r_dout_valid <= 1'b1;
        if (r_zero) begin
          r_quotient  <= '1;
          r_remainder <= r_dvd_lo;
          r_dbz       <= 1'b1;
        end else begin
          r_quotient  <= r_qneg ? -r_dq : r_dq;
          r_remainder <= r_rneg ? -r_prem : r_prem;
          r_dbz       <= 1'b0;
        end
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign dout_valid = r_dout_valid;
  assign quotient   = r_quotient;
  assign remainder  = r_remainder;
  assign dbz        = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (N=8, DW=7) using a result
// scoreboard filled at start and drained on dout_valid.
module tb_seq_divider;

  localparam int N   = 8;
  localparam int DW  = 7;
  localparam int LAT = N + 1;

  typedef struct packed {
    logic [N-1:0]  q;
    logic [DW-1:0] r;
    logic          z;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          signed_op = 1'b0;
  logic [N-1:0]  dividendin = '0;
  logic [DW-1:0] divisorin = '0;
  logic          busy;
  logic          dout_valid;
  logic [N-1:0]  quotient;
  logic [DW-1:0] remainder;
  logic          dbz;

  int   n_asserts = 0;
  int   n_fail = 0;
  int   n_ops = 0;
  res_t sb[$];

  seq_divider #(
    .N(N),
    .DW(DW),
    .SIGNED_EN(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .signed_op (signed_op),
    .dividendin(dividendin),
    .divisorin (divisorin),
    .busy      (busy),
    .dout_valid(dout_valid),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division (truncates toward zero, remainder has dividend sign).
  function automatic res_t model(input logic s, input logic [N-1:0] a, input logic [DW-1:0] b);
    res_t m;
    int   ai, bi, qi, ri;
    if (b == '0) begin
      m.q = '1;
      m.r = a[DW-1:0];
      m.z = 1'b1;
    end else begin
      if (s) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'(a);
        bi = int'(b);
      end
      qi  = ai / bi;
      ri  = ai % bi;
      m.q = qi[N-1:0];
      m.r = ri[DW-1:0];
      m.z = 1'b0;
    end
    return m;
  endfunction

  // Called at a negedge; returns at the negedge right after the capturing edge.
  task automatic launch(input logic s, input logic [N-1:0] a, input logic [DW-1:0] b,
                        input bit expect_result);
    start      = 1'b1;
    signed_op  = s;
    dividendin = a;
    divisorin  = b;
    if (expect_result) sb.push_back(model(s, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // m0 = number of edges already elapsed since the capturing edge.
  task automatic collect(input string tag, input int m0);
    int            m;
    bit            seen;
    logic          busy_before;
    logic [N-1:0]  q_hold;
    logic [N-1:0]  q_late;
    res_t          e;
    m           = m0;
    seen        = 1'b0;
    busy_before = 1'b0;
    q_hold      = quotient;
    q_late      = quotient;
    while (m < 30 && !seen) begin
      @(negedge clk);
      m++;
      if (m == LAT - 1) begin
        busy_before = busy;
        q_late      = quotient;
      end
      if (dout_valid) seen = 1'b1;
    end
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, " latency"}, m, LAT);
    check({tag, " busy_run"}, busy_before, 1'b1);
    check({tag, " busy_done"}, busy, 1'b0);
    check({tag, " q_held_run"}, q_late, q_hold);
    check({tag, " quotient"}, quotient, e.q);
    check({tag, " remainder"}, remainder, e.r);
    check({tag, " dbz"}, dbz, e.z);
    n_ops++;
    $display("op %0d %s: q=0x%h r=0x%h dbz=%b latency=%0d", n_ops, tag, quotient, remainder,
             dbz, m);
  endtask

  initial begin
    bit            saw_valid;
    logic          rs;
    logic [N-1:0]  ra;
    logic [DW-1:0] rb;

    repeat (2) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst dout_valid", dout_valid, 1'b0);
    check("rst quotient", quotient, 8'h00);
    check("rst remainder", remainder, 7'h00);
    check("rst dbz", dbz, 1'b0);

    reset = 1'b1;
    launch(1'b0, 8'd200, 7'd7, 1'b1);
    collect("u200_7", 0);

    launch(1'b1, 8'h9C, 7'd7, 1'b1);
    collect("s-100_7", 0);

    launch(1'b1, 8'h80, 7'h7F, 1'b1);
    collect("s-128_-1", 0);

    launch(1'b0, 8'd55, 7'd0, 1'b1);
    collect("u55_0", 0);
    @(negedge clk);
    check("valid_pulse", dout_valid, 1'b0);
    check("dbz_hold q", quotient, 8'hFF);
    check("dbz_hold dbz", dbz, 1'b1);

    launch(1'b0, 8'd200, 7'd7, 1'b1);
    repeat (2) @(negedge clk);
    start      = 1'b1;
    dividendin = 8'd10;
    divisorin  = 7'd3;
    @(negedge clk);
    start = 1'b0;
    collect("ignore_start", 3);

    launch(1'b0, 8'd200, 7'd7, 1'b1);
    collect("b2b_first", 0);
    launch(1'b1, 8'hF6, 7'h03, 1'b1);
    collect("b2b_second", 0);

    launch(1'b0, 8'd100, 7'd9, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy, 1'b0);
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_valid |= dout_valid;
    end
    check("abort no_valid", saw_valid, 1'b0);
    check("abort q_held", quotient, 8'hFD);
    check("abort r_held", remainder, 7'h7F);
    $display("abort op: busy=%b q=0x%h r=0x%h", busy, quotient, remainder);

    launch(1'b0, 8'd200, 7'd7, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst dout_valid", dout_valid, 1'b0);
    check("midrst quotient", quotient, 8'h00);
    check("midrst remainder", remainder, 7'h00);
    check("midrst dbz", dbz, 1'b0);
    $display("reset op: busy=%b q=0x%h r=0x%h dbz=%b", busy, quotient, remainder, dbz);
    @(negedge clk);
    reset = 1'b1;
    launch(1'b0, 8'd200, 7'd7, 1'b1);
    collect("after_reset", 0);

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = N'($urandom);
      rb = DW'($urandom_range(1, 127));
      launch(rs, ra, rb, 1'b1);
      collect("random", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 8, dividend and quotient width (N >= 2).
REQ-002 SHALL have parameter DW, default 7, divisor and remainder width (2 <= DW <= N).
REQ-003 SHALL have parameter SIGNED_EN, default 1; 0 ties off signed mode and removes sign logic.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a division; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of an operation in progress.
REQ-008 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-009 dividendin  input  N  dividend; captured with start.
REQ-010 divisorin  input  DW  divisor; captured with start.
REQ-011 busy  output  1  high while an operation is in progress (RUN or FIX).
REQ-012 dout_valid  output  1  one-cycle pulse; results valid in that cycle.
REQ-013 quotient  output  N  quotient.
REQ-014 remainder  output  DW  remainder.
REQ-015 dbz  output  1  divide-by-zero flag for the current result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FIX only.
REQ-017 IDLE: start=1 at an edge SHALL capture operands, load the iteration counter with N-1 and enter RUN; start while busy SHALL be ignored.
REQ-018 On capture in signed mode, negative operands SHALL be converted to magnitudes, and the quotient sign (XOR of the operand signs) and remainder sign (the dividend sign) SHALL be stored.
REQ-019 RUN SHALL perform one restoring step per cycle, MSB first, on a DW+1-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor, keep the difference and set the quotient bit to 1 when it is non-negative, else restore and set 0.
REQ-020 RUN SHALL last exactly N cycles, then enter FIX; FIX SHALL apply sign correction and return to IDLE.
REQ-021 Latency SHALL be fixed: with the start edge at t0, dout_valid SHALL be high in the cycle after edge t0+N+1; busy SHALL be high from t0 to t0+N+1.
REQ-022 Signed results SHALL truncate toward zero, with the remainder taking the dividend's sign; the most-negative value divided by -1 SHALL wrap (quotient = most negative, remainder 0).
REQ-023 Divisor 0 SHALL give quotient all-ones, remainder = dividendin[DW-1:0] and dbz=1 with the same latency, with no sign correction applied.
REQ-024 quotient, remainder and dbz SHALL hold their last result until the next dout_valid, and SHALL NOT change during RUN.
REQ-025 abort=1 in RUN or FIX SHALL return the FSM to IDLE on that edge, with no dout_valid and the outputs unchanged; abort in IDLE SHALL have no effect, and abort SHALL take priority over start.
REQ-026 start and dout_valid in the same cycle (in IDLE) SHALL be accepted, allowing back-to-back operations every N+2 cycles.

Reset
REQ-027 reset low SHALL force IDLE at any time, including mid-operation, with busy=0, dout_valid=0, quotient=0, remainder=0, dbz=0, and all internal registers cleared.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Package div_pkg SHALL hold the FSM state enum (IDLE, RUN, FIX) and the default values of N and DW.
REQ-030 A sub-module div_step SHALL implement one combinational restoring iteration (DW+1-bit shift, subtract, select, quotient bit); seq_divider SHALL instantiate it once.
REQ-031 Counter width SHALL be the clog2 of N.

Verification (N=8, DW=7)
REQ-032 Unsigned 200/7 -> quotient 0x1C (28), remainder 4, dbz=0, with dout_valid exactly 9 edges after start.
REQ-033 Signed -100/7 -> quotient 0xF2 (-14), remainder 7'h7E (-2); signed -128/-1 (7'h7F) -> quotient 0x80, remainder 0.
REQ-034 Unsigned 55/0 -> quotient 0xFF, remainder 55, dbz=1, same latency.
REQ-035 start pulsed again 3 cycles into a 200/7 operation with 10/3 -> ignored; the result is still 28 r4. A back-to-back start on the dout_valid cycle -> the second result follows 9 edges later.
REQ-036 abort at cycle 4 of RUN -> IDLE, no dout_valid, previous outputs held; reset low at cycle 5 of RUN -> all outputs 0 and busy=0 immediately, and a fresh 200/7 after release is correct.
